// File: rtl/layer_control_unit_if.sv
// Handshake and datapath-control bundle between the network sequencer, the
// layer control unit and the AG/ALU/output-buffer datapath.
interface layer_control_unit_if #(
  parameter int ADDR_W = 8,
  parameter int NEUR_W = 1
);
  logic              start;
  logic              forget;
  logic              busy;
  logic              done;
  logic              AG_rst;
  logic              AG_read;
  logic [ADDR_W-1:0] AG_addr;
  logic              ALU_rst;
  logic              ALU_forget;
  logic              ALU_acc_en;
  logic              out_we;
  logic [NEUR_W-1:0] neuron_idx;

  modport master (
    output start, forget,
    input  busy, done, AG_rst, AG_read, AG_addr,
    input  ALU_rst, ALU_forget, ALU_acc_en, out_we, neuron_idx
  );

  modport slave (
    input  start, forget,
    output busy, done, AG_rst, AG_read, AG_addr,
    output ALU_rst, ALU_forget, ALU_acc_en, out_we, neuron_idx
  );
endinterface

// File: rtl/layer_control_unit.sv
// Sequencer for one fully-connected layer: drives AG reads and ALU accumulation
// for N_NEURONS x N_INPUTS steps, writing one result per neuron.
module layer_control_unit #(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 2,
  parameter int READ_LAT  = 1,
  parameter int ADDR_W    = 8,
  parameter int NEUR_W    = 1
) (
  input logic                 clk,
  input logic                 reset,
  layer_control_unit_if.slave bus
);

  localparam int I_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int D_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [I_W-1:0]    LAST_I = I_W'(N_INPUTS - 1);
  localparam logic [D_W-1:0]    LAST_D = D_W'(READ_LAT - 1);
  localparam logic [NEUR_W-1:0] LAST_N = NEUR_W'(N_NEURONS - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(N_INPUTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NEUR_W-1:0]   n_q, n_d;
  logic [I_W-1:0]      i_q, i_d;
  logic [D_W-1:0]      d_q, d_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                fgt_q, fgt_d;
  logic                flush;
  logic                ag_read;
  logic [READ_LAT-1:0] rd_pipe;
  logic [READ_LAT:0]   rd_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      d_q     <= '0;
      base_q  <= '0;
      fgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      d_q     <= d_d;
      base_q  <= base_d;
      fgt_q   <= fgt_d;
    end
  end

  // Read strobe delay line: bit READ_LAT-1 marks data arriving at the ALU.
  // A forget flushes it so reads already in flight never get accumulated.
  assign rd_shift = {rd_pipe, ag_read};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= rd_shift[READ_LAT-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    d_d     = d_q;
    base_d  = base_q;
    fgt_d   = 1'b0;
    flush   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        n_d    = '0;
        i_d    = '0;
        base_d = '0;
        if (bus.start) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        i_d     = '0;
        d_d     = '0;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (bus.forget) begin
          state_d = S_CLEAR;
          fgt_d   = 1'b1;
          flush   = 1'b1;
          i_d     = '0;
        end else if (i_q == LAST_I) begin
          state_d = S_DRAIN;
          d_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (bus.forget) begin
          state_d = S_CLEAR;
          fgt_d   = 1'b1;
          flush   = 1'b1;
          i_d     = '0;
        end else if (d_q == LAST_D) begin
          state_d = S_WRITE;
        end else begin
          d_d = d_q + 1'b1;
        end
      end

      S_WRITE: begin
        if (n_q == LAST_N) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR;
          n_d     = n_q + 1'b1;
          base_d  = base_q + STRIDE;
          i_d     = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        n_d     = '0;
        i_d     = '0;
        base_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Every output is a decode of registered state only.
  assign ag_read        = (state_q == S_FETCH);
  assign bus.AG_read    = ag_read;
  assign bus.AG_rst     = (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign bus.AG_addr    = base_q + ADDR_W'(i_q);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.ALU_rst    = (state_q == S_CLEAR);
  assign bus.ALU_forget = (state_q == S_CLEAR) && fgt_q;
  assign bus.ALU_acc_en = rd_pipe[READ_LAT-1];
  assign bus.out_we     = (state_q == S_WRITE);
  assign bus.neuron_idx = ((state_q == S_IDLE) || (state_q == S_DONE)) ? '0 : n_q;

endmodule

// File: tb/tb_layer_control_unit.sv
// Scoreboard bench for layer_control_unit: expected strobe events are queued at
// stimulus time and matched by a negedge monitor against two DUT instances.
module tb_layer_control_unit;

  localparam int NI  = 4;
  localparam int NN  = 2;
  localparam int BIG = 32'h7fff_ffff;

  typedef struct {
    int d;
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;

  ev_t q_rd[$];
  ev_t q_acc[$];
  ev_t q_clr[$];
  ev_t q_we[$];
  ev_t q_done[$];

  layer_control_unit_if #(.ADDR_W(8), .NEUR_W(1)) if1 ();
  layer_control_unit_if #(.ADDR_W(8), .NEUR_W(1)) if3 ();

  layer_control_unit #(
    .N_INPUTS(NI), .N_NEURONS(NN), .READ_LAT(1), .ADDR_W(8), .NEUR_W(1)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  layer_control_unit #(
    .N_INPUTS(NI), .N_NEURONS(NN), .READ_LAT(3), .ADDR_W(8), .NEUR_W(1)
  ) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: cyc=%0d, required finish before time limit", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_ev(input string name, input ev_t e, input int d, input int act);
    nvec++;
    if (e.d != d || e.cyc != cyc || e.val != act) begin
      nfail++;
      $display("FAIL %s: got dut%0d cyc=%0d val=%0d, expected dut%0d cyc=%0d val=%0d",
               name, d, cyc, act, e.d, e.cyc, e.val);
    end
  endtask

  task automatic unexpected(input string name, input int d, input int act);
    nvec++;
    nfail++;
    $display("FAIL %s: got unexpected event dut%0d cyc=%0d val=%0d, expected none",
             name, d, cyc, act);
  endtask

  task automatic mon(input int d, input logic rd, input logic [7:0] addr, input logic acc,
                     input logic rs, input logic fg, input logic we, input logic idx,
                     input logic dn);
    ev_t e;
    if (rd === 1'b1) begin
      if (q_rd.size() == 0) unexpected("AG_read", d, int'(addr));
      else begin e = q_rd.pop_front(); cmp_ev("AG_read", e, d, int'(addr)); end
    end
    if (acc === 1'b1) begin
      if (q_acc.size() == 0) unexpected("ALU_acc_en", d, 1);
      else begin e = q_acc.pop_front(); cmp_ev("ALU_acc_en", e, d, 1); end
    end
    if (rs === 1'b1 || fg === 1'b1) begin
      if (q_clr.size() == 0) unexpected("clear", d, 2 * int'(fg) + int'(idx));
      else begin e = q_clr.pop_front(); cmp_ev("clear", e, d, 2 * int'(fg) + int'(idx)); end
    end
    if (we === 1'b1) begin
      if (q_we.size() == 0) unexpected("out_we", d, int'(idx));
      else begin e = q_we.pop_front(); cmp_ev("out_we", e, d, int'(idx)); end
    end
    if (dn === 1'b1) begin
      if (q_done.size() == 0) unexpected("done", d, 1);
      else begin e = q_done.pop_front(); cmp_ev("done", e, d, 1); end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if1.AG_read, if1.AG_addr, if1.ALU_acc_en, if1.ALU_rst, if1.ALU_forget,
        if1.out_we, if1.neuron_idx, if1.done);
    mon(1, if3.AG_read, if3.AG_addr, if3.ALU_acc_en, if3.ALU_rst, if3.ALU_forget,
        if3.out_we, if3.neuron_idx, if3.done);
  end

  // kind: 0 read(addr) 1 acc 2 clear(2*forget+idx) 3 write(idx) 4 done
  task automatic push_ev(input int kind, input int d, input int c, input int v, input int ab);
    ev_t e;
    if (c > ab) return;
    e.d = d; e.cyc = c; e.val = v;
    case (kind)
      0: q_rd.push_back(e);
      1: q_acc.push_back(e);
      2: q_clr.push_back(e);
      3: q_we.push_back(e);
      default: q_done.push_back(e);
    endcase
  endtask

  // Expected timeline of one pass whose start is sampled at the end of cycle k.
  // fi < NI: forget during FETCH step fi; fi >= NI: forget during DRAIN cycle fi-NI.
  task automatic push_pass(input int d, input int k, input int rl, input int fn,
                           input int fi, input int ab, output int done_c);
    int t, c, tf;
    bit fgd, fgf, restart;
    t = k + 1;
    fgd = 0;
    for (int n = 0; n < NN; n++) begin
      fgf = 0;
      restart = 1;
      while (restart) begin
        restart = 0;
        push_ev(2, d, t, (fgf ? 2 : 0) + n, ab);
        fgf = 0;
        t++;
        for (int i = 0; i < NI; i++) begin
          push_ev(0, d, t, n * NI + i, ab);
          if (!fgd && n == fn && i == fi) begin
            for (int j = 0; j <= i; j++) begin
              c = t - i + j;
              if (c + rl <= t) push_ev(1, d, c + rl, 1, ab);
            end
            t++;
            fgd = 1; fgf = 1; restart = 1;
            break;
          end
          t++;
        end
        if (!restart) begin
          if (!fgd && n == fn && fi >= NI) begin
            tf = t + fi - NI;
            for (int j = 0; j < NI; j++) begin
              c = t - NI + j;
              if (c + rl <= tf) push_ev(1, d, c + rl, 1, ab);
            end
            t = tf + 1;
            fgd = 1; fgf = 1; restart = 1;
          end else begin
            for (int j = 0; j < NI; j++) push_ev(1, d, t - NI + j + rl, 1, ab);
            t += rl;
            push_ev(3, d, t, n, ab);
            t++;
          end
        end
      end
    end
    push_ev(4, d, t, 1, ab);
    done_c = t;
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) if1.start = v; else if3.start = v;
  endtask

  task automatic set_forget(input int d, input logic v);
    if (d == 0) if1.forget = v; else if3.forget = v;
  endtask

  function automatic logic get_busy(input int d);
    return (d == 0) ? if1.busy : if3.busy;
  endfunction

  task automatic wait_cyc(input int m);
    while (cyc < m) @(negedge clk);
  endtask

  task automatic run_pass(input int d, input int rl, input int fn, input int fi);
    int k, dc;
    @(negedge clk);
    k = cyc;
    push_pass(d, k, rl, fn, fi, BIG, dc);
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    chk("busy_in_pass", get_busy(d), 1);
    if (fn >= 0) begin
      wait_cyc(k + 2 + fn * (NI + rl + 2) + fi);
      set_forget(d, 1'b1);
      @(negedge clk);
      set_forget(d, 1'b0);
    end
    wait_cyc(dc + 1);
    chk("busy_after_done", get_busy(d), 0);
  endtask

  initial begin
    int k, d1, d2, dc;
    ev_t e;
    reset = 1'b1;
    if1.start = 1'b0; if1.forget = 1'b0;
    if3.start = 1'b0; if3.forget = 1'b0;

    // Reset defaults, idle with start low
    wait_cyc(2);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_AG_rst", if1.AG_rst, 1);
      chk("rst_busy", if1.busy, 0);
      chk("rst_done", if1.done, 0);
      chk("rst_AG_addr", if1.AG_addr, 0);
      chk("rst_neuron_idx", if1.neuron_idx, 0);
      chk("rst_strobes", {if1.AG_read, if1.ALU_rst, if1.ALU_forget, if1.ALU_acc_en, if1.out_we}, 0);
      chk("rst_AG_rst_rl3", if3.AG_rst, 1);
      chk("rst_busy_rl3", if3.busy, 0);
    end

    // Nominal pass, forget mid-fetch, forget on last fetch cycle of neuron 1
    run_pass(0, 1, -1, -1);
    run_pass(0, 1, 0, 2);
    run_pass(0, 1, 1, NI - 1);

    // READ_LAT=3: nominal pass, then forget in the middle of neuron-1 DRAIN
    run_pass(1, 3, -1, -1);
    run_pass(1, 3, 1, NI + 1);

    // Reset during neuron-1 FETCH, then a fresh pass from n=0
    @(negedge clk);
    k = cyc;
    push_pass(0, k, 1, -1, -1, k + 10, dc);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    wait_cyc(k + 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", if1.busy, 0);
    chk("midrst_AG_rst", if1.AG_rst, 1);
    chk("midrst_AG_addr", if1.AG_addr, 0);
    chk("midrst_strobes", {if1.AG_read, if1.ALU_rst, if1.ALU_acc_en, if1.out_we, if1.done}, 0);
    run_pass(0, 1, -1, -1);

    // start held high through a pass: second pass begins right after DONE
    @(negedge clk);
    k = cyc;
    push_pass(0, k, 1, -1, -1, BIG, d1);
    push_pass(0, d1 + 1, 1, -1, -1, BIG, d2);
    set_start(0, 1'b1);
    wait_cyc(d1 + 1);
    chk("held_idle_gap", if1.busy, 0);
    @(negedge clk);
    chk("held_restart", if1.busy, 1);
    set_start(0, 1'b0);
    wait_cyc(d2 + 1);
    chk("held_end_busy", if1.busy, 0);

    // forget in IDLE has no effect
    set_forget(0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("idle_forget", {if1.ALU_forget, if1.ALU_rst, if1.busy}, 0);
    end
    set_forget(0, 1'b0);

    repeat (6) @(negedge clk);
    while (q_rd.size() > 0) begin e = q_rd.pop_front(); unexpected("missing_AG_read", e.d, e.cyc); end
    while (q_acc.size() > 0) begin e = q_acc.pop_front(); unexpected("missing_acc_en", e.d, e.cyc); end
    while (q_clr.size() > 0) begin e = q_clr.pop_front(); unexpected("missing_clear", e.d, e.cyc); end
    while (q_we.size() > 0) begin e = q_we.pop_front(); unexpected("missing_out_we", e.d, e.cyc); end
    while (q_done.size() > 0) begin e = q_done.pop_front(); unexpected("missing_done", e.d, e.cyc); end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/layer_control_unit.md
Name: layer_control_unit

Overview:
Parametrised sequencer for one fully-connected neural-network layer. It drives the address generator (AG) and the MAC ALU through N_NEURONS x N_INPUTS multiply-accumulate steps, and writes one result per neuron. It adds a start/busy/done handshake, absolute address generation, read-latency compensation and per-neuron forget (restart) to the original reset/forget control unit. It sits between the top-level network sequencer and the AG/ALU/output-buffer datapath.

Parameters:
N_INPUTS, 4, inputs (weights) per neuron; must be >= 1.
N_NEURONS, 2, neurons in the layer; must be >= 1.
READ_LAT, 1, cycles from AG_read to data valid at the ALU; range 1..4.
ADDR_W, 8, AG address width; requires N_INPUTS*N_NEURONS <= 2^ADDR_W.
NEUR_W, 1, neuron index width; requires N_NEURONS <= 2^NEUR_W.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  begin a layer pass; sampled only in IDLE.
forget  in  1  discard the current neuron's accumulation and restart that neuron.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at the end of the layer pass.
AG_rst  out  1  address generator reset.
AG_read  out  1  weight/input read strobe.
AG_addr  out  ADDR_W  read address.
ALU_rst  out  1  clears the accumulator.
ALU_forget  out  1  marks an accumulator clear caused by forget.
ALU_acc_en  out  1  accumulate the data presented this cycle.
out_we  out  1  write the accumulator to the output buffer.
neuron_idx  out  NEUR_W  index of the current neuron.

Behaviour:
- All outputs are registered or pure state decode. There is no combinational path from input to output.
- Reset: state goes to IDLE on the next edge, from any state.
  - Reset values: AG_rst=1. busy, done, AG_read, ALU_rst, ALU_forget, ALU_acc_en and out_we are 0. AG_addr=0, neuron_idx=0.
  - The read-latency delay line is cleared.
- States and transitions:
  - IDLE: AG_rst=1. If start=1, go to CLEAR with n=0. Otherwise stay.
  - CLEAR (1 cycle): ALU_rst=1, AG_rst=1, AG_addr=n*N_INPUTS. Go to FETCH with i=0.
  - FETCH (N_INPUTS cycles): AG_read=1, AG_addr=n*N_INPUTS+i. After i=N_INPUTS-1, go to DRAIN.
  - DRAIN (READ_LAT cycles): AG_read=0. Waits for the delay line to empty, then goes to WRITE.
  - WRITE (1 cycle): out_we=1, neuron_idx=n. If n=N_NEURONS-1, go to DONE; otherwise n++ and go to CLEAR.
  - DONE (1 cycle): done=1, then go to IDLE.
- ALU_acc_en equals AG_read delayed by exactly READ_LAT cycles, through a shift register.
- neuron_idx is valid and equal to n in every state from CLEAR through WRITE.
- Latency: start sampled at edge k gives done high in cycle k+1+N_NEURONS*(N_INPUTS+READ_LAT+2).
- forget:
  - Sampled high in FETCH or DRAIN: the next state is CLEAR for the same n, with ALU_forget=1 and ALU_rst=1 in that cycle. The delay line is flushed, so ALU_acc_en=0 from that CLEAR onward until new reads mature. i restarts at 0.
  - Ignored in IDLE, CLEAR, WRITE and DONE.
- Simultaneous events:
  - reset takes priority over forget and start.
  - forget on the last FETCH cycle still restarts the neuron.
  - start while busy=1 is ignored; no queuing.
  - start held high through DONE starts a new pass on the IDLE cycle that follows.
- Address arithmetic is unsigned. The AG_addr maximum is N_INPUTS*N_NEURONS-1, so there is no wrap.
- With N_NEURONS=1, WRITE goes directly to DONE.

Test Plan:
1. Reset defaults: reset=1 for 2 cycles, then 0 → AG_rst=1, busy=0, done=0, AG_addr=0 and all strobes 0; state stays IDLE with start=0.
2. Nominal pass (4/2/1), start pulse at edge k:
   - CLEAR at k+1 and k+8; AG_addr 0,1,2,3 on cycles k+2..k+5 and 4,5,6,7 on cycles k+9..k+12.
   - ALU_acc_en on k+3..k+6 and k+10..k+13.
   - out_we at k+7 (neuron_idx=0) and k+14 (neuron_idx=1); done only at k+15, then busy=0.
3. Forget mid-fetch: forget=1 during cycle k+4 (AG_addr=2) → k+5 has ALU_rst=ALU_forget=1 and ALU_acc_en=0; addresses 0..3 are refetched at k+6..k+9; done at k+19.
4. READ_LAT=3: ALU_acc_en lags AG_read by 3 cycles; DRAIN lasts 3 cycles; done at k+1+2*(4+3+2)=k+19.
5. Reset mid-operation: reset=1 during neuron-1 FETCH → next cycle is IDLE with all strobes 0 and ALU_acc_en=0; a new start restarts from n=0, AG_addr=0.
6. start held high through a whole pass is ignored while busy; a second pass begins on the IDLE cycle after DONE. forget in IDLE produces no ALU_forget.
